zxuno_regbus_arbiter: RTL and testbench
=======================================

// Module: zxuno_regbus_arbiter
// PURPOSE
//  Shares the 8-bit ZXUNO register bus (reg_addr/reg_wdata/reg_we/reg_re/reg_rdata) between the
//  Z80 port decoder (read/write level strobes) and an internal host (boot/OSD controller).
//  Turns asynchronous multi-cycle CPU strobes into single-cycle bus strobes; CPU has fixed priority.
// PARAMETERS
//  SYNC_STAGES   2     synchroniser depth on cpu_rd/cpu_wr (>=2)
//  WPROT_BASE    8'h80 first register address covered by write protect (optional feature only)
// PORTS
//  clk          in   1  system clock (sole clock)
//  rst_n        in   1  asynchronous, active-low reset
//  cpu_addr     in   8  register address from port decoder; stable while strobe asserted
//  cpu_rd       in   1  level: CPU reading data port (async to clk)
//  cpu_wr       in   1  level: CPU writing data port (async to clk)
//  cpu_din      in   8  CPU write data; stable while cpu_wr asserted
//  cpu_dout     out  8  last CPU read result, held until next CPU read capture
//  cpu_overrun  out  1  sticky: a CPU edge was dropped because one was already pending
//  host_req     in   1  host transaction request, held until host_ack
//  host_we      in   1  1=write, 0=read; qualified by host_req
//  host_addr    in   8  host register address
//  host_wdata   in   8  host write data
//  host_ack     out  1  one-cycle completion pulse; host_rdata valid in same cycle for reads
//  host_rdata   out  8  host read result
//  wprot        in   1  write-protect enable (used only with REGARB_WPROT_EN)
//  reg_addr     out  8  register bus address
//  reg_wdata    out  8  register bus write data
//  reg_we       out  1  one-cycle write strobe
//  reg_re       out  1  one-cycle read strobe; reg_rdata sampled on the following clk edge
//  reg_rdata    in   8  register bus read data
//  busy         out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset: every output and register 0; pending flags cleared; FSM=IDLE; edge detectors disarmed.
//  - Sync: cpu_rd/cpu_wr pass SYNC_STAGES flops; rising edge of synced level sets rd_pend/wr_pend
//    and latches cpu_addr (and cpu_din for writes). Detector arms only after synced level seen 0,
//    so a strobe held high across reset release produces no access.
//  - Same-cycle rd and wr edges: write pended, read dropped, cpu_overrun<=1.
//  - Edge arriving while same-type flag still pending: dropped, cpu_overrun<=1 (sticky until reset).
//  - FSM: IDLE, CPU_WR, CPU_RD, CPU_CAP, HOST_WR, HOST_RD, HOST_CAP, HOST_ACK.
//    IDLE: wr_pend->CPU_WR; else rd_pend->CPU_RD; else host_req->HOST_WR/HOST_RD by host_we.
//    CPU_WR: reg_we=1, clear wr_pend -> IDLE.  CPU_RD: reg_re=1 -> CPU_CAP.
//    CPU_CAP: cpu_dout<=reg_rdata, clear rd_pend -> IDLE.
//    HOST_WR: reg_we=1 -> HOST_ACK.  HOST_RD: reg_re=1 -> HOST_CAP.
//    HOST_CAP: host_rdata<=reg_rdata -> HOST_ACK.  HOST_ACK: host_ack=1, host_req ignored -> IDLE.
//  - reg_addr/reg_wdata registered, driven from latched CPU or host values in the strobe cycle; hold
//    last value otherwise. Host transactions are never pre-empted; CPU waits <=3 cycles.
//  - CPU write latency: synced edge -> reg_we within 1..4 cycles; worst case total SYNC_STAGES+5
//    clk, well inside a Z80 I/O cycle. host_ack: 2 cycles (write) / 3 cycles (read) from grant.
// CONFIGURATION
//  REGARB_WPROT_EN defined: when wprot=1, CPU writes with latched addr >= WPROT_BASE complete
//    CPU_WR with reg_we=0 (silently discarded); host writes never blocked.
//  Not defined: wprot ignored, WPROT_BASE unused, all CPU writes reach the bus.
// STRUCTURE
//  Shared package zxuno_regarb_pkg: FSM state encoding, SYNC_STAGES default, WPROT_BASE default.
//  Sub-module zxuno_strobe_sync (synchroniser + armed rising-edge detector), instantiated for
//  cpu_rd and cpu_wr. Arbitration FSM and datapath registers in this module.
// TESTING
//  1 CPU write: cpu_addr=8'h0B, cpu_din=8'h5A, cpu_wr high 30 clk -> exactly one reg_we, addr 0B/data 5A.
//  2 CPU read: reg_rdata=8'hC3 at addr 8'h40 -> one reg_re, cpu_dout=8'hC3 next cycle, held after.
//  3 Contention: host_req read 8'h10 asserted same cycle wr_pend set -> CPU_WR first, then host,
//    host_ack with host_rdata=reg_rdata at 10; no lost strobe.
//  4 Host in HOST_RD when CPU edge arrives -> host completes, CPU reg_we <=3 cycles later.
//  5 cpu_wr high across rst_n release -> no reg_we; two wr edges 2 clk apart -> overrun=1.
//  6 REGARB_WPROT_EN, wprot=1: CPU write 8'h85 -> no reg_we; 8'h7F -> reg_we; host write 85 -> reg_we.

Source files
------------

// File: rtl/zxuno_regbus_arbiter_pkg.sv
// Shared constants for the ZXUNO register bus arbiter.
// FSM state encoding and parameter defaults live here.
package zxuno_regarb_pkg;

    localparam int         REGARB_SYNC_STAGES = 2;
    localparam logic [7:0] REGARB_WPROT_BASE  = 8'h80;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CPU_WR   = 3'd1;
    localparam logic [2:0] S_CPU_RD   = 3'd2;
    localparam logic [2:0] S_CPU_CAP  = 3'd3;
    localparam logic [2:0] S_HOST_WR  = 3'd4;
    localparam logic [2:0] S_HOST_RD  = 3'd5;
    localparam logic [2:0] S_HOST_CAP = 3'd6;
    localparam logic [2:0] S_HOST_ACK = 3'd7;

endpackage

// File: rtl/zxuno_regbus_arbiter_if.sv
// ZXUNO 8-bit register bus.
// The arbiter is the master; register file(s) are the slave.
interface zxuno_regbus_if;

    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );

endinterface

// File: rtl/zxuno_regbus_arbiter_strobe_sync.sv
// Synchroniser plus armed rising-edge detector for one CPU strobe.
// The detector only arms after the flushed synced level reads 0.
module zxuno_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lvl,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] r_fill;
    logic              r_armed;
    logic              r_prev;
    logic              w_lvl;
    logic              w_ready;

    assign w_lvl   = r_sync[STAGES-1];
    assign w_ready = r_fill[STAGES-1];

    // Shift the level in; arm once a post-reset sample of 0 is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_lvl};
            r_fill <= {r_fill[STAGES-2:0], 1'b1};
            r_prev <= w_lvl;
            if (w_ready && !w_lvl)
                r_armed <= 1'b1;
        end
    end

    assign o_rise = r_armed & w_lvl & ~r_prev;

endmodule

// File: rtl/zxuno_regbus_arbiter.sv
// Register bus arbiter: Z80 port strobes (fixed priority) vs host.
// Optional CPU write protect: define REGARB_WPROT_EN.
module zxuno_regbus_arbiter
    import zxuno_regarb_pkg::*;
#(
    parameter int         SYNC_STAGES = REGARB_SYNC_STAGES,
    parameter logic [7:0] WPROT_BASE  = REGARB_WPROT_BASE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_overrun,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    input  logic       wprot,
    zxuno_regbus_if.master bus,
    output logic       busy
);

    logic [2:0] r_state;
    logic       r_wr_pend;
    logic       r_rd_pend;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_rd_addr;
    logic       r_overrun;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_wr_blk;
    logic [7:0] r_cpu_dout;
    logic [7:0] r_host_rdata;
    logic       w_wr_rise;
    logic       w_rd_rise;
    logic       w_wr_clr;
    logic       w_rd_clr;
    logic       w_blk_next;

    zxuno_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lvl  (cpu_wr),
        .o_rise (w_wr_rise)
    );

    zxuno_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lvl  (cpu_rd),
        .o_rise (w_rd_rise)
    );

`ifdef REGARB_WPROT_EN
    assign w_blk_next = wprot && (r_wr_addr >= WPROT_BASE);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{wprot, WPROT_BASE};
    assign w_blk_next   = 1'b0;
`endif

    assign w_wr_clr = (r_state == S_CPU_WR);
    assign w_rd_clr = (r_state == S_CPU_CAP);

    // Pending flags and CPU latches; colliding or repeated edges set overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_wr_addr <= 8'h00;
            r_wr_data <= 8'h00;
            r_rd_addr <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_clr)
                r_wr_pend <= 1'b0;
            if (w_rd_clr)
                r_rd_pend <= 1'b0;
            if (w_wr_rise) begin
                if (r_wr_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_wr_pend <= 1'b1;
                    r_wr_addr <= cpu_addr;
                    r_wr_data <= cpu_din;
                end
            end
            if (w_rd_rise) begin
                if (w_wr_rise || r_rd_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rd_pend <= 1'b1;
                    r_rd_addr <= cpu_addr;
                end
            end
        end
    end

    // Arbitration FSM; bus address/data are loaded on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_reg_addr   <= 8'h00;
            r_reg_wdata  <= 8'h00;
            r_wr_blk     <= 1'b0;
            r_cpu_dout   <= 8'h00;
            r_host_rdata <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_wr_pend) begin
                        r_state     <= S_CPU_WR;
                        r_reg_addr  <= r_wr_addr;
                        r_reg_wdata <= r_wr_data;
                        r_wr_blk    <= w_blk_next;
                    end else if (r_rd_pend) begin
                        r_state    <= S_CPU_RD;
                        r_reg_addr <= r_rd_addr;
                    end else if (host_req) begin
                        r_reg_addr <= host_addr;
                        if (host_we) begin
                            r_state     <= S_HOST_WR;
                            r_reg_wdata <= host_wdata;
                        end else begin
                            r_state <= S_HOST_RD;
                        end
                    end
                end
                S_CPU_WR:   r_state <= S_IDLE;
                S_CPU_RD:   r_state <= S_CPU_CAP;
                S_CPU_CAP: begin
                    r_cpu_dout <= bus.reg_rdata;
                    r_state    <= S_IDLE;
                end
                S_HOST_WR:  r_state <= S_HOST_ACK;
                S_HOST_RD:  r_state <= S_HOST_CAP;
                S_HOST_CAP: begin
                    r_host_rdata <= bus.reg_rdata;
                    r_state      <= S_HOST_ACK;
                end
                S_HOST_ACK: r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.reg_we    = ((r_state == S_CPU_WR) && !r_wr_blk)
                         || (r_state == S_HOST_WR);
    assign bus.reg_re    = (r_state == S_CPU_RD) || (r_state == S_HOST_RD);
    assign host_ack      = (r_state == S_HOST_ACK);
    assign host_rdata    = r_host_rdata;
    assign cpu_dout      = r_cpu_dout;
    assign cpu_overrun   = r_overrun;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_zxuno_regbus_arbiter.sv
// Self-checking bench for zxuno_regbus_arbiter.
// Build with +define+REGARB_WPROT_EN to exercise write protect.
module tb_zxuno_regbus_arbiter;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        bit         host;
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
        int         hold;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] cpu_addr;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_overrun;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       wprot;
    logic       busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    ev_t  ev_q[$];
    logic [7:0] mem   [256];
    logic [7:0] model [256];

    zxuno_regbus_if bus ();

    zxuno_regbus_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_addr    (cpu_addr),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_overrun (cpu_overrun),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .wprot       (wprot),
        .bus         (bus),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file slave: write on strobe, registered read data.
    always @(posedge clk) begin
        if (bus.reg_we)
            mem[bus.reg_addr] <= bus.reg_wdata;
        if (bus.reg_re)
            bus.reg_rdata <= mem[bus.reg_addr];
    end

    // Bus monitor: log every strobe with its cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.reg_we)
                ev_q.push_back('{1'b1, bus.reg_addr, bus.reg_wdata, cyc});
            if (bus.reg_re)
                ev_q.push_back('{1'b0, bus.reg_addr, 8'h00, cyc});
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t ev_at(input int idx);
        ev_t e;
        e = '{1'b0, 8'h00, 8'h00, 0};
        if (idx >= 0 && idx < ev_q.size())
            e = ev_q[idx];
        return e;
    endfunction

    task automatic host_xfer(input bit we, input logic [7:0] a,
                             input logic [7:0] d, output logic [7:0] r,
                             output bit got);
        @(negedge clk);
        host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
        got = 1'b0; r = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1; r = host_rdata;
                break;
            end
        end
        host_req = 1'b0;
    endtask

    // One transaction from CPU or host, checked against the model memory.
    task automatic run_op(input string nm, input bit host, input bit we,
                          input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp, input int hold,
                          input bit exp_we);
        int         n0;
        logic [7:0] r;
        bit         got;
        ev_t        e;
        n0 = ev_q.size();
        if (!host) begin
            @(negedge clk);
            cpu_addr = a; cpu_din = d;
            if (we) cpu_wr = 1'b1; else cpu_rd = 1'b1;
            repeat (hold) @(negedge clk);
            cpu_wr = 1'b0; cpu_rd = 1'b0;
            repeat (8) @(negedge clk);
            r = cpu_dout;
        end else begin
            host_xfer(we, a, d, r, got);
            check({nm, " ack"}, {31'd0, got}, 32'd1);
            repeat (2) @(negedge clk);
        end
        e = ev_at(n0);
        if (we && !exp_we) begin
            check({nm, " no strobe"}, ev_q.size() - n0, 0);
        end else begin
            check({nm, " strobes"}, ev_q.size() - n0, 1);
            if (we) begin
                check({nm, " wr ev"}, {e.we, e.addr, e.data}, {1'b1, a, d});
                model[a] = d;
            end else begin
                check({nm, " rd ev"}, {e.we, e.addr}, {1'b0, a});
                check({nm, " rdata"}, r, exp);
            end
        end
    endtask

    initial begin
        vec_t       tbl[8];
        int         n0;
        int         t_ack;
        logic [7:0] r;
        logic [7:0] a;
        logic [7:0] d;
        bit         got;
        bit         seen;
        ev_t        e;

        tbl[0] = '{0, 1, 8'h0B, 8'h5A, 8'h00, 30};
        tbl[1] = '{0, 0, 8'h40, 8'h00, 8'hC3, 5};
        tbl[2] = '{1, 1, 8'h10, 8'hA5, 8'h00, 0};
        tbl[3] = '{1, 0, 8'h10, 8'h00, 8'hA5, 0};
        tbl[4] = '{0, 0, 8'h0B, 8'h00, 8'h5A, 5};
        tbl[5] = '{1, 0, 8'h40, 8'h00, 8'hC3, 0};
        tbl[6] = '{0, 1, 8'hFF, 8'h01, 8'h00, 4};
        tbl[7] = '{1, 0, 8'hFF, 8'h00, 8'h01, 0};

        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'(i * 7 + 3);
            model[i] = 8'(i * 7 + 3);
        end
        mem[8'h40]   = 8'hC3;
        model[8'h40] = 8'hC3;

        rst_n = 1'b0; cpu_addr = 0; cpu_rd = 0; cpu_wr = 0; cpu_din = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        wprot = 0;
        repeat (3) @(negedge clk);
        check("reset bus", {bus.reg_we, bus.reg_re, bus.reg_addr,
                            bus.reg_wdata}, 0);
        check("reset cpu", {cpu_dout, cpu_overrun}, 0);
        check("reset host", {host_ack, host_rdata, busy}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), tbl[i].host, tbl[i].we,
                   tbl[i].addr, tbl[i].data, tbl[i].exp, tbl[i].hold, 1);
        check("cpu_dout held", cpu_dout, 8'h5A);

        // CPU write pends in the same cycle the host requests a read.
        @(negedge clk);
        cpu_addr = 8'h0C; cpu_din = 8'h3C; cpu_wr = 1'b1;
        n0 = ev_q.size();
        repeat (3) @(negedge clk);
        host_we = 1'b0; host_addr = 8'h10; host_req = 1'b1; got = 0; r = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1; r = host_rdata; host_req = 1'b0;
                break;
            end
        end
        host_req = 1'b0; cpu_wr = 1'b0;
        repeat (8) @(negedge clk);
        check("contend ack", {31'd0, got}, 1);
        check("contend rdata", r, model[8'h10]);
        check("contend strobes", ev_q.size() - n0, 2);
        e = ev_at(n0);
        check("contend cpu first", {e.we, e.addr, e.data},
              {1'b1, 8'h0C, 8'h3C});
        e = ev_at(n0 + 1);
        check("contend host second", {e.we, e.addr}, {1'b0, 8'h10});
        model[8'h0C] = 8'h3C;

        // CPU edge arrives while the host read is on the bus.
        @(negedge clk);
        host_we = 1'b0; host_addr = 8'h20; host_req = 1'b1;
        n0 = ev_q.size(); seen = 0; got = 0; t_ack = 0; r = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.reg_re) begin
                seen = 1;
                break;
            end
        end
        cpu_addr = 8'h21; cpu_din = 8'h77; cpu_wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1; r = host_rdata; t_ack = cyc;
                break;
            end
        end
        host_req = 1'b0;
        repeat (4) @(negedge clk);
        cpu_wr = 1'b0;
        repeat (8) @(negedge clk);
        check("midhost re seen", {31'd0, seen}, 1);
        check("midhost ack", {31'd0, got}, 1);
        check("midhost rdata", r, model[8'h20]);
        check("midhost strobes", ev_q.size() - n0, 2);
        e = ev_at(n0 + 1);
        check("midhost cpu wr", {e.we, e.addr, e.data},
              {1'b1, 8'h21, 8'h77});
        check("midhost cpu wait", {31'd0, (e.cyc - t_ack >= 1) &&
                                          (e.cyc - t_ack <= 3)}, 1);
        model[8'h21] = 8'h77;

        // Randomised traffic against the model memory.
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 3);
            a = 8'($urandom);
            d = 8'($urandom);
            run_op($sformatf("rnd%0d", i), k[1], k[0], a, d, model[a],
                   $urandom_range(3, 8), 1);
        end
        check("no overrun", {31'd0, cpu_overrun}, 0);
        check("idle", {31'd0, busy}, 0);

        // Strobe held across reset release must not produce an access.
        @(negedge clk);
        cpu_addr = 8'h30; cpu_din = 8'h99; cpu_wr = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n0 = ev_q.size();
        repeat (10) @(negedge clk);
        cpu_wr = 1'b0;
        repeat (8) @(negedge clk);
        check("held reset no wr", ev_q.size() - n0, 0);
        check("held reset no ovr", {31'd0, cpu_overrun}, 0);

        // Two write edges two clocks apart: second is dropped.
        n0 = ev_q.size();
        @(negedge clk);
        cpu_addr = 8'h33; cpu_din = 8'h44; cpu_wr = 1'b1;
        @(negedge clk); cpu_wr = 1'b0;
        @(negedge clk); cpu_wr = 1'b1;
        @(negedge clk); cpu_wr = 1'b0;
        repeat (10) @(negedge clk);
        check("double edge strobes", ev_q.size() - n0, 1);
        check("overrun set", {31'd0, cpu_overrun}, 1);
        model[8'h33] = 8'h44;
        repeat (5) @(negedge clk);
        check("overrun sticky", {31'd0, cpu_overrun}, 1);

        wprot = 1'b1;
`ifdef REGARB_WPROT_EN
        run_op("wp cpu 85", 0, 1, 8'h85, 8'h11, 8'h00, 4, 0);
        run_op("wp cpu 7F", 0, 1, 8'h7F, 8'h22, 8'h00, 4, 1);
        run_op("wp host 85", 1, 1, 8'h85, 8'h33, 8'h00, 0, 1);
        run_op("wp readback", 1, 0, 8'h85, 8'h00, 8'h33, 0, 1);
`else
        run_op("nowp cpu 85", 0, 1, 8'h85, 8'h11, 8'h00, 4, 1);
        run_op("nowp readback", 0, 0, 8'h85, 8'h00, 8'h11, 5, 1);
`endif
        wprot = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
